mario_dma_gen: RTL and testbench

MARIO_DMA_GEN -- requirements
Module: mario_dma_gen

---
 rtl/mario_dma_gen.sv | 178 +++++++++++++++++
 tb/tb_mario_dma_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mario_dma_gen.sv
// Byte-wide DMA engine that copies a source range or fills a destination range.
// Four clock-enabled ticks per byte: RD, LATCH, WR, NEXT.
module mario_dma_gen #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 11
) (
    input  logic          I_CLK_48M,
    input  logic          I_RSTn,
    input  logic          I_CEN_4M,
    input  logic          I_DMA_TRIG,
    input  logic [AW-1:0] I_SRC_BASE,
    input  logic [AW-1:0] I_DST_BASE,
    input  logic [LW-1:0] I_LEN,
    input  logic          I_MODE,
    input  logic [DW-1:0] I_FILL_DATA,
    input  logic [DW-1:0] I_DMA_DS,
    input  logic          I_BUSAK,
    output logic          O_BUSRQ,
    output logic [AW-1:0] O_DMA_AS,
    output logic [AW-1:0] O_DMA_AD,
    output logic [DW-1:0] O_DMA_DD,
    output logic          O_DMA_CES,
    output logic          O_DMA_CED,
    output logic          O_DMA_WE,
    output logic          O_BUSY,
    output logic          O_DONE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RD    = 3'd2,
        S_LATCH = 3'd3,
        S_WR    = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_trig_d;
    logic          r_hist_vld;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [LW-1:0] r_cnt;
    logic          r_mode;
    logic [DW-1:0] r_fill;

    logic          r_busrq;
    logic [AW-1:0] r_as;
    logic [AW-1:0] r_ad;
    logic [DW-1:0] r_dd;
    logic          r_ces;
    logic          r_ced;
    logic          r_we;
    logic          r_busy;
    logic          r_done;

    logic          w_trig_rise;
    logic [AW-1:0] w_src_adv;
    logic          w_busrq;
    logic          w_ces;
    logic          w_ced;
    logic          w_we;
    logic          w_busy;
    logic          w_done;

    // History must be valid so a trigger already high out of reset is not an edge.
    assign w_trig_rise = I_CEN_4M & r_hist_vld & ~r_trig_d & I_DMA_TRIG;
    assign w_src_adv   = r_mode ? r_src : AW'(r_src + 1'b1);

    always_ff @(posedge I_CLK_48M) begin
        if (!I_RSTn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (I_CEN_4M) begin
            case (r_state)
                S_IDLE:  if (w_trig_rise) w_state_nxt = (I_LEN != '0) ? S_REQ : S_DONE;
                S_REQ:   if (I_BUSAK) w_state_nxt = S_RD;
                S_RD:    w_state_nxt = S_LATCH;
                S_LATCH: w_state_nxt = S_WR;
                S_WR:    w_state_nxt = S_NEXT;
                S_NEXT: begin
                    if (r_cnt == LW'(1)) w_state_nxt = S_DONE;
                    else if (I_BUSAK)    w_state_nxt = S_RD;
                    else                 w_state_nxt = S_REQ;
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state and registered below.
    always_comb begin
        w_busrq = 1'b0;
        w_ces   = 1'b0;
        w_ced   = 1'b0;
        w_we    = 1'b0;
        case (w_state_nxt)
            S_REQ:   w_busrq = 1'b1;
            S_RD:    begin w_busrq = 1'b1; w_ces = 1'b1; end
            S_LATCH: begin w_busrq = 1'b1; w_ces = 1'b1; end
            S_WR:    begin w_busrq = 1'b1; w_ced = 1'b1; w_we = 1'b1; end
            S_NEXT:  w_busrq = 1'b1;
            default: ;
        endcase
        w_busy = (w_state_nxt != S_IDLE);
        w_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    end

    always_ff @(posedge I_CLK_48M) begin
        if (!I_RSTn) begin
            r_trig_d   <= 1'b0;
            r_hist_vld <= 1'b0;
            r_src      <= '0;
            r_dst      <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_fill     <= '0;
            r_busrq    <= 1'b0;
            r_as       <= '0;
            r_ad       <= '0;
            r_dd       <= '0;
            r_ces      <= 1'b0;
            r_ced      <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busrq <= w_busrq;
            r_ces   <= w_ces;
            r_ced   <= w_ced;
            r_we    <= w_we;
            r_busy  <= w_busy;
            r_done  <= w_done;
            if (I_CEN_4M) begin
                r_trig_d   <= I_DMA_TRIG;
                r_hist_vld <= 1'b1;
            end
            if (r_state == S_IDLE && w_trig_rise) begin
                r_src  <= I_SRC_BASE;
                r_dst  <= I_DST_BASE;
                r_cnt  <= I_LEN;
                r_mode <= I_MODE;
                r_fill <= I_FILL_DATA;
            end
            if (I_CEN_4M && r_state == S_LATCH)
                r_dd <= r_mode ? r_fill : I_DMA_DS;
            if (I_CEN_4M && r_state == S_NEXT) begin
                r_src <= w_src_adv;
                r_dst <= AW'(r_dst + 1'b1);
                r_cnt <= LW'(r_cnt - 1'b1);
            end
            // Addresses update only on entry to their phase and hold otherwise.
            if (w_state_nxt == S_RD && r_state != S_RD)
                r_as <= (r_state == S_NEXT) ? w_src_adv : r_src;
            if (w_state_nxt == S_WR && r_state != S_WR)
                r_ad <= r_dst;
        end
    end

    assign O_BUSRQ   = r_busrq;
    assign O_DMA_AS  = r_as;
    assign O_DMA_AD  = r_ad;
    assign O_DMA_DD  = r_dd;
    assign O_DMA_CES = r_ces;
    assign O_DMA_CED = r_ced;
    assign O_DMA_WE  = r_we;
    assign O_BUSY    = r_busy;
    assign O_DONE    = r_done;

endmodule

// File: tb/tb_mario_dma_gen.sv
// Scoreboard bench for mario_dma_gen: expected writes queued at start, popped on each write strobe.
module tb_mario_dma_gen;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 11;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cen = 1'b0;
    logic          trig = 1'b0;
    logic [AW-1:0] src_b = '0;
    logic [AW-1:0] dst_b = '0;
    logic [LW-1:0] len = '0;
    logic          mode = 1'b0;
    logic [DW-1:0] fill = '0;
    logic [DW-1:0] ds;
    logic          busak = 1'b1;
    logic          busrq;
    logic [AW-1:0] as_o;
    logic [AW-1:0] ad_o;
    logic [DW-1:0] dd_o;
    logic          ces, ced, we, busy, done;

    logic [DW-1:0]    src_mem [0:(1<<AW)-1];
    logic [AW+DW-1:0] exp_q [$];
    logic [AW+DW-1:0] e;

    int   errors = 0;
    int   checks = 0;
    int   wr_count = 0;
    int   done_count = 0;
    int   rq_rises = 0;
    int   tick_cnt = 0;
    int   t_rd = 0;
    int   t_done = 0;
    int   div = 0;
    logic rd_seen = 1'b0;
    logic rq_prev = 1'b0;
    logic fill_chk = 1'b0;
    logic [AW-1:0] fill_src = '0;

    always #5 clk = ~clk;

    mario_dma_gen #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .I_CLK_48M  (clk),
        .I_RSTn     (rstn),
        .I_CEN_4M   (cen),
        .I_DMA_TRIG (trig),
        .I_SRC_BASE (src_b),
        .I_DST_BASE (dst_b),
        .I_LEN      (len),
        .I_MODE     (mode),
        .I_FILL_DATA(fill),
        .I_DMA_DS   (ds),
        .I_BUSAK    (busak),
        .O_BUSRQ    (busrq),
        .O_DMA_AS   (as_o),
        .O_DMA_AD   (ad_o),
        .O_DMA_DD   (dd_o),
        .O_DMA_CES  (ces),
        .O_DMA_CED  (ced),
        .O_DMA_WE   (we),
        .O_BUSY     (busy),
        .O_DONE     (done)
    );

    assign ds = src_mem[as_o];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One tick in four, changed just after the rising edge.
    always @(posedge clk) begin
        if (cen) tick_cnt <= tick_cnt + 1;
        #2;
        div = (div + 1) % 4;
        cen = (div == 0);
    end

    always @(negedge clk) begin
        if (busrq && !rq_prev) rq_rises++;
        rq_prev = busrq;
        if (ces && !rd_seen) begin
            rd_seen = 1'b1;
            t_rd    = tick_cnt;
        end
        if (done) begin
            done_count++;
            t_done = tick_cnt;
        end
        if (we && cen) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexp_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(ad_o), 32'(e[AW+DW-1:DW]));
                check("wr_data", 32'(dd_o), 32'(e[DW-1:0]));
            end
            check("rq_at_wr", 32'(busrq), 32'd1);
            if (fill_chk) check("fill_as", 32'(as_o), 32'(fill_src));
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!cen) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        wait_ticks(2);
        trig = 1'b0;
    endtask

    task automatic start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                         input logic m, input logic [DW-1:0] f);
        logic [AW-1:0] a;
        logic [AW-1:0] sa;
        @(negedge clk);
        src_b = s; dst_b = d; len = n; mode = m; fill = f;
        for (int i = 0; i < int'(n); i++) begin
            a  = AW'(d + AW'(i));
            sa = AW'(s + AW'(i));
            exp_q.push_back({a, m ? f : src_mem[sa]});
        end
        rd_seen = 1'b0;
        pulse_trig();
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        k = 0;
        while (done_count == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_count == d0) check("done_timeout", 32'd0, 32'd1);
        wait_ticks(3);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int k;
        k = 0;
        while (wr_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (wr_count < target) check("wr_timeout", 32'(wr_count), 32'(target));
    endtask

    int d0, w0, r0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) src_mem[i] = DW'($urandom);

        repeat (4) @(negedge clk);
        check("rst_busrq", 32'(busrq), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_strb",  32'({ces, ced, we, done}), 0);
        check("rst_addr",  32'({as_o, ad_o}), 0);
        check("rst_dd",    32'(dd_o), 0);
        rstn = 1'b1;
        wait_ticks(3);

        // Long copy with grant tied high.
        d0 = done_count; w0 = wr_count; r0 = rq_rises;
        start(10'h100, 10'h000, 11'h180, 1'b0, 8'h00);
        wait_done(d0, 20000);
        check("cp_writes", 32'(wr_count - w0), 32'd384);
        check("cp_ticks",  32'(t_done - t_rd), 32'd1536);
        check("cp_done",   32'(done_count - d0), 32'd1);
        check("cp_rq",     32'(rq_rises - r0), 32'd1);
        check("cp_q",      32'(exp_q.size()), 0);
        check("cp_busy",   32'(busy), 0);

        // Fill across the address wrap.
        d0 = done_count; w0 = wr_count;
        fill_src = 10'h155; fill_chk = 1'b1;
        start(10'h155, 10'h3FE, 11'd4, 1'b1, 8'hE5);
        wait_done(d0, 500);
        fill_chk = 1'b0;
        check("fl_writes", 32'(wr_count - w0), 32'd4);
        check("fl_done",   32'(done_count - d0), 32'd1);
        check("fl_dd",     32'(dd_o), 32'hE5);
        check("fl_as",     32'(as_o), 32'h155);
        check("fl_q",      32'(exp_q.size()), 0);

        // Zero-length trigger.
        d0 = done_count; r0 = rq_rises; w0 = wr_count;
        start(10'h000, 10'h000, 11'd0, 1'b0, 8'h00);
        check("z_busy",  32'(busy), 0);
        wait_ticks(3);
        check("z_done",  32'(done_count - d0), 32'd1);
        check("z_rq",    32'(rq_rises - r0), 0);
        check("z_wr",    32'(wr_count - w0), 0);

        // Grant withdrawn for 10 ticks after byte 3.
        d0 = done_count; w0 = wr_count; r0 = rq_rises;
        start(10'h200, 10'h280, 11'd8, 1'b0, 8'h00);
        wait_writes(w0 + 3, 400);
        busak = 1'b0;
        wait_ticks(10);
        check("ps_rq_hold", 32'(busrq), 32'd1);
        check("ps_stall",   32'(wr_count - w0), 32'd3);
        busak = 1'b1;
        wait_done(d0, 1000);
        check("ps_writes", 32'(wr_count - w0), 32'd8);
        check("ps_rq",     32'(rq_rises - r0), 32'd1);
        check("ps_done",   32'(done_count - d0), 32'd1);
        check("ps_q",      32'(exp_q.size()), 0);

        // Retrigger ignored, then reset at byte 5.
        d0 = done_count; w0 = wr_count;
        start(10'h040, 10'h300, 11'd16, 1'b0, 8'h00);
        wait_writes(w0 + 2, 400);
        src_b = 10'h3A0; dst_b = 10'h1A0; mode = 1'b1;
        pulse_trig();
        wait_writes(w0 + 5, 400);
        @(negedge clk);
        rstn = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        check("rs_rq_drop", 32'(busrq), 0);
        repeat (3) @(negedge clk);
        check("rs_outs", 32'({busrq, busy, ces, ced, we, done}), 0);
        check("rs_addr", 32'({as_o, ad_o}), 0);
        check("rs_dd",   32'(dd_o), 0);
        exp_q.delete();
        rstn = 1'b1;
        wait_ticks(4);
        check("rs_trig_hi", 32'(busy), 0);
        check("rs_nodone",  32'(done_count - d0), 0);
        trig = 1'b0;
        wait_ticks(2);
        d0 = done_count; w0 = wr_count;
        start(10'h3F0, 10'h010, 11'd4, 1'b0, 8'h00);
        wait_done(d0, 500);
        check("rs_writes", 32'(wr_count - w0), 32'd4);
        check("rs_done",   32'(done_count - d0), 32'd1);
        check("rs_q",      32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
